// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
// Snoops a multiplexed 7-segment bus (segment lines plus digit enables) and
// recovers the displayed hex digits. Each digit position is captured once per
// stable period, decoded back to a nibble, and a whole frame is published once
// every position has been seen.
// Optional feature: define SEG7_DP_EN to add the decimal-point line (i_dp) to
// the snooped bus and publish the captured dp bits on o_dp with each frame.

module seg7_frame_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_an,
`ifdef SEG7_DP_EN
    input  logic                    i_dp,
    output logic [NUM_DIGITS-1:0]   o_dp,
`endif
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_frame_valid,
    output logic                    o_frame_err,
    output logic [NUM_DIGITS-1:0]   o_seen
);

`ifdef SEG7_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {
        S_WAIT,
        S_HELD
    } state_t;

    state_t                  state;
    logic [SW-1:0]           bus_now;
    logic [SW-1:0]           smp;
    logic [7:0]              cnt;
    logic [7:0]              cnt_next;
    logic                    diff;
    logic                    capture;
    logic                    dec_ok;
    logic [3:0]              dec_nib;
    logic [4*NUM_DIGITS-1:0] dig_buf;
    logic [NUM_DIGITS-1:0]   err_buf;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_buf;
`endif

    // Map a segment pattern back to its hex value; bit 4 flags a known pattern
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = 5'h10;
            7'h30:   r = 5'h11;
            7'h6D:   r = 5'h12;
            7'h79:   r = 5'h13;
            7'h33:   r = 5'h14;
            7'h5B:   r = 5'h15;
            7'h5F:   r = 5'h16;
            7'h70:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h7B:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h1F:   r = 5'h1B;
            7'h4E:   r = 5'h1C;
            7'h3D:   r = 5'h1D;
            7'h4F:   r = 5'h1E;
            7'h47:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

`ifdef SEG7_DP_EN
    assign bus_now = {i_dp, i_an, i_seg};
`else
    assign bus_now = {i_an, i_seg};
`endif

    // Work out the stability count this edge will load and whether it captures
    always_comb begin
        diff = (bus_now != smp);
        if (diff) begin
            cnt_next = 8'd1;
        end else if (cnt < STABLE) begin
            cnt_next = cnt + 8'd1;
        end else begin
            cnt_next = cnt;
        end
        capture = ((state == S_WAIT) || diff) && (cnt_next == STABLE) && $onehot(i_an);
        {dec_ok, dec_nib} = decode(i_seg);
    end

    // Register the bus every edge and track how long it has held its value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp <= '0;
            cnt <= 8'd0;
        end else begin
            smp <= bus_now;
            cnt <= cnt_next;
        end
    end

    // One capture per stable period: hold off until the bus changes again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else if (capture) begin
            state <= S_HELD;
        end else if (diff) begin
            state <= S_WAIT;
        end
    end

    // Collect decoded digits per position and publish the frame once all are seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_buf       <= '0;
            err_buf       <= '0;
            o_seen        <= '0;
            o_digits      <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
`ifdef SEG7_DP_EN
            dp_buf        <= '0;
            o_dp          <= '0;
`endif
        end else begin
            o_frame_valid <= 1'b0;
            if (&o_seen) begin
                o_digits      <= dig_buf;
                o_frame_err   <= |err_buf;
                o_frame_valid <= 1'b1;
`ifdef SEG7_DP_EN
                o_dp          <= dp_buf;
`endif
            end
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (capture && i_an[k]) begin
                    dig_buf[4*k +: 4] <= dec_ok ? dec_nib : 4'h0;
                    err_buf[k]        <= ~dec_ok;
                    o_seen[k]         <= 1'b1;
`ifdef SEG7_DP_EN
                    dp_buf[k]         <= i_dp;
`endif
                end else if (&o_seen) begin
                    err_buf[k]        <= 1'b0;
                    o_seen[k]         <= 1'b0;
                end
            end
        end
    end

endmodule
